imm_chunker: RTL and testbench

IMM_CHUNKER -- requirements
Module: imm_chunker

---
 rtl/imm_chunker.sv | 163 ++++++++++++++++
 tb/tb_imm_chunker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_chunker.sv
// imm_chunker: splits a signed constant into a stream of immediate chunks.
// The decoder rebuilds the constant by sign-extending the first chunk, then
// shifting left 8 and OR-ing in the low byte of each later chunk.
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_value, i_valid, o_ready constant to encode, offered / accepted
//   o_immRaw, o_immSel        current chunk field and type (00 none, 01 I, 10 J)
//   o_valid, i_ready          chunk valid / downstream accept
//   o_last, o_chunkCount      final-chunk marker, chunks in this word (1..4)
module imm_chunker #(
  parameter int DATA_WIDTH    = 36,
  parameter int SELECT_WIDTH  = 2,
  parameter int IMM_MAX_WIDTH = 14,
  parameter int I_IMM_WIDTH   = 8,
  parameter int J_IMM_WIDTH   = 14
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [DATA_WIDTH-1:0]    i_value,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [IMM_MAX_WIDTH-1:0] o_immRaw,
  output logic [SELECT_WIDTH-1:0]  o_immSel,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last,
  output logic [2:0]               o_chunkCount
);

  // Two guard bits so every shifted J field can be read without running off the top.
  localparam int VW = DATA_WIDTH + 2;

  localparam logic [SELECT_WIDTH-1:0] IMMSEL_NONE   = 2'b00;
  localparam logic [SELECT_WIDTH-1:0] IMMSEL_I_TYPE = 2'b01;
  localparam logic [SELECT_WIDTH-1:0] IMMSEL_J_TYPE = 2'b10;

  typedef enum logic {IDLE, EMIT} state_t;

  typedef struct packed {
    logic [IMM_MAX_WIDTH-1:0] raw;
    logic [SELECT_WIDTH-1:0]  sel;
  } chunk_t;

  state_t                   state_q, state_d;
  logic [VW-1:0]            v_q, v_d;
  logic [1:0]               idx_q, idx_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [IMM_MAX_WIDTH-1:0] raw_q, raw_d;
  logic [SELECT_WIDTH-1:0]  sel_q, sel_d;
  logic                     last_q, last_d;
  logic                     valid_q, valid_d;

  logic   fire, accept;
  chunk_t c;

  // True when v is representable as a w-bit two's-complement number.
  function automatic logic fits(input logic [VW-1:0] v, input int w);
    logic [VW-1:0] s;
    s = $signed(v) >>> (w - 1);
    return (&s) || (~|s);
  endfunction

  function automatic logic [2:0] count_of(input logic [VW-1:0] v);
    if (fits(v, J_IMM_WIDTH))                   return 3'd1;
    if (fits(v, J_IMM_WIDTH + I_IMM_WIDTH))     return 3'd2;
    if (fits(v, J_IMM_WIDTH + 2 * I_IMM_WIDTH)) return 3'd3;
    return 3'd4;
  endfunction

  // Chunk idx of a word with n chunks. Only the first chunk can be J type; a
  // single-chunk word is J only when it does not fit the narrower I field.
  function automatic chunk_t chunk_of(input logic [VW-1:0] v, input logic [2:0] n,
                                      input logic [1:0] idx);
    chunk_t        r;
    logic [2:0]    k;
    logic [VW-1:0] sh;
    r = '0;
    if (idx == 2'd0 && (n != 3'd1 || !fits(v, I_IMM_WIDTH))) begin
      sh    = v >> {n - 3'd1, 3'b000};
      r.raw = sh[IMM_MAX_WIDTH-1:0];
      r.sel = IMMSEL_J_TYPE;
    end else begin
      k     = n - 3'd1 - {1'b0, idx};
      sh    = v >> {k, 3'b000};
      r.raw = {{(IMM_MAX_WIDTH-I_IMM_WIDTH){1'b0}}, sh[I_IMM_WIDTH-1:0]};
      r.sel = IMMSEL_I_TYPE;
    end
    return r;
  endfunction

  assign fire    = valid_q && i_ready;
  assign o_ready = (state_q == IDLE) || (fire && last_q);
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    raw_d   = raw_q;
    sel_d   = sel_q;
    last_d  = last_q;
    valid_d = valid_q;
    c       = '0;
    if (accept) begin
      // A new word always wins; it also covers the back-to-back case where the
      // previous word's last chunk retires in this same cycle.
      v_d     = {{(VW-DATA_WIDTH){i_value[DATA_WIDTH-1]}}, i_value};
      cnt_d   = count_of(v_d);
      idx_d   = 2'd0;
      c       = chunk_of(v_d, cnt_d, 2'd0);
      raw_d   = c.raw;
      sel_d   = c.sel;
      last_d  = (cnt_d == 3'd1);
      valid_d = 1'b1;
      state_d = EMIT;
    end else if (fire && last_q) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = 3'd0;
      raw_d   = '0;
      sel_d   = IMMSEL_NONE;
      last_d  = 1'b0;
      valid_d = 1'b0;
    end else if (fire) begin
      idx_d  = idx_q + 2'd1;
      c      = chunk_of(v_q, cnt_q, idx_d);
      raw_d  = c.raw;
      sel_d  = c.sel;
      last_d = ({1'b0, idx_d} == cnt_q - 3'd1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      v_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      raw_q   <= '0;
      sel_q   <= IMMSEL_NONE;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      raw_q   <= raw_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign o_immRaw     = raw_q;
  assign o_immSel     = sel_q;
  assign o_valid      = valid_q;
  assign o_last       = last_q;
  assign o_chunkCount = cnt_q;

endmodule

// File: tb/tb_imm_chunker.sv
module tb_imm_chunker;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [35:0] i_value;
  logic        i_valid;
  logic        o_ready;
  logic [13:0] o_immRaw;
  logic [1:0]  o_immSel;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic [2:0]  o_chunkCount;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 1'b0;

  imm_chunker dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_value(i_value), .i_valid(i_valid),
    .o_ready(o_ready), .o_immRaw(o_immRaw), .o_immSel(o_immSel), .o_valid(o_valid),
    .i_ready(i_ready), .o_last(o_last), .o_chunkCount(o_chunkCount)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [13:0] raw;
    logic [1:0]  sel;
    logic        last;
    logic [2:0]  cnt;
    logic [35:0] word;
  } exp_t;

  exp_t q[$];
  exp_t mdl[4];
  int   mdl_n;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick the chunk count from the numeric range of the value, then
  // slice the signed value into a 14-bit head and 8-bit tails.
  function automatic void build(input logic [35:0] v);
    longint s;
    int n;
    s = longint'($signed(v));
    if (s >= -(64'sd1 << 13) && s < (64'sd1 << 13))      n = 1;
    else if (s >= -(64'sd1 << 21) && s < (64'sd1 << 21)) n = 2;
    else if (s >= -(64'sd1 << 29) && s < (64'sd1 << 29)) n = 3;
    else                                                  n = 4;
    mdl_n = n;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && n == 1 && s >= -128 && s <= 127) begin
        mdl[i].raw = 14'(s & 64'hFF);
        mdl[i].sel = 2'b01;
      end else if (i == 0) begin
        mdl[i].raw = 14'((s >>> (8 * (n - 1))) & 64'h3FFF);
        mdl[i].sel = 2'b10;
      end else begin
        mdl[i].raw = 14'((s >>> (8 * (n - 1 - i))) & 64'hFF);
        mdl[i].sel = 2'b01;
      end
      mdl[i].last = (i == n - 1);
      mdl[i].cnt  = 3'(n);
      mdl[i].word = v;
    end
  endfunction

  // Scoreboard update on each active edge (pre-update values are sampled).
  longint acc;
  bit     first = 1'b1;
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      if (o_valid && i_ready && q.size() > 0) begin
        if (first) acc = (o_immSel == 2'b10) ? longint'($signed(o_immRaw))
                                             : longint'($signed(o_immRaw[7:0]));
        else       acc = (acc <<< 8) | longint'(o_immRaw[7:0]);
        first = 1'b0;
        if (o_last) begin
          check("rebuild", acc, longint'($signed(q[0].word)));
          first = 1'b1;
        end
        void'(q.pop_front());
      end
      if (i_valid && o_ready) begin
        build(i_value);
        for (int i = 0; i < mdl_n; i++) q.push_back(mdl[i]);
      end
    end
  end

  always @(negedge i_rst_n) begin
    q.delete();
    first = 1'b1;
  end

  // Per-cycle output compare against the scoreboard.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (q.size() > 0)
        check("chunk", {o_valid, o_immRaw, o_immSel, o_last, o_chunkCount},
                       {1'b1, q[0].raw, q[0].sel, q[0].last, q[0].cnt});
      else
        check("idle", {o_valid, o_immRaw, o_immSel}, {1'b0, 14'h0, 2'b00});
    end
  end

  always @(posedge i_clk) if (rnd_ready) #1 i_ready = 1'($urandom_range(0, 1));

  task automatic send(input logic [35:0] v);
    int n = 0;
    i_value = v;
    i_valid = 1'b1;
    do begin
      @(posedge i_clk);
      n++;
    end while (!o_ready && n < 50);
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: word 0x%0h not accepted", v);
    end
    #1;
    i_valid = 1'b0;
    i_value = 36'($urandom());
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  logic [35:0] tbl[13] = '{36'h00000007F, 36'h000000080, 36'hFFFFFFF80, 36'hFFFFFFF7F,
                           36'h000001FFF, 36'h000002000, 36'hFFFFFE000, 36'hFFFFFDFFF,
                           36'h0001FFFFF, 36'h000200000, 36'h01FFFFFFF, 36'h020000000,
                           36'h7FFFFFFFF};

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_value = '0;

    // Pin the reference model with hand-derived chunks.
    build(36'h800000000);
    check("mdl_n_800", mdl_n, 4);
    check("mdl_head_800", mdl[0].raw, 14'h3800);
    check("mdl_head_sel_800", mdl[0].sel, 2'b10);
    build(36'h000012345);
    check("mdl_12345", {mdl[0].raw, mdl[1].raw, mdl[1].last}, {14'h0123, 14'h0045, 1'b1});
    build(36'h0000000C8);
    check("mdl_c8", {mdl[0].raw, mdl[0].sel}, {14'h00C8, 2'b10});
    build(36'hFFFFFFFFF);
    check("mdl_m1", {mdl[0].raw, mdl[0].sel}, {14'h00FF, 2'b01});

    #12;
    check("rst_outputs", {o_valid, o_last, o_immRaw, o_immSel, o_chunkCount}, 21'h0);
    @(negedge i_clk); i_rst_n = 1'b1;
    step();
    check("ready_after_rst", o_ready, 1);

    send(36'h000000005);
    check("w5", {o_valid, o_immRaw, o_immSel, o_last, o_chunkCount},
                {1'b1, 14'h0005, 2'b01, 1'b1, 3'd1});
    step();
    send(36'hFFFFFFFFF);
    check("wm1", {o_immRaw, o_immSel, o_last}, {14'h00FF, 2'b01, 1'b1});
    step();
    send(36'h0000000C8);
    check("wc8", {o_immRaw, o_immSel, o_last}, {14'h00C8, 2'b10, 1'b1});
    step();

    // Stall on the head chunk.
    i_ready = 1'b0;
    send(36'h000012345);
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", {o_valid, o_immRaw, o_immSel, o_last, o_chunkCount},
                          {1'b1, 14'h0123, 2'b10, 1'b0, 3'd2});
      if (i < 2) step();
    end
    i_ready = 1'b1;
    step();
    check("stall_tail", {o_immRaw, o_immSel, o_last, o_chunkCount},
                        {14'h0045, 2'b01, 1'b1, 3'd2});
    step();
    check("stall_done", o_valid, 0);

    send(36'h800000000);
    check("min_head", {o_immRaw, o_immSel, o_chunkCount}, {14'h3800, 2'b10, 3'd4});
    for (int i = 0; i < 3; i++) begin
      step();
      check("min_tail", {o_immRaw, o_immSel, o_last, o_chunkCount},
                        {14'h0000, 2'b01, 1'(i == 2), 3'd4});
    end
    step();

    // Back-to-back words: the second is accepted as the first retires.
    send(36'h000000005);
    send(36'h0000000C8);
    check("b2b_valid", o_valid, 1);
    check("b2b_chunk", {o_immRaw, o_immSel}, {14'h00C8, 2'b10});
    step();

    // Reset in the middle of a word.
    send(36'h800000000);
    step();
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", {o_valid, o_immRaw, o_immSel, o_last}, 17'h0);
    #2;
    i_rst_n = 1'b1;
    step();
    check("midrst_ready", o_ready, 1);
    send(36'h000000005);
    check("after_rst", {o_immRaw, o_immSel, o_last, o_chunkCount},
                       {14'h0005, 2'b01, 1'b1, 3'd1});
    step();

    // Range boundaries with random backpressure.
    rnd_ready = 1'b1;
    foreach (tbl[i]) send(tbl[i]);
    rnd_ready = 1'b0;
    #2;
    i_ready = 1'b1;
    for (int n = 0; n < 60 && q.size() > 0; n++) step();
    step();
    check("drained", {q.size() == 0, o_valid}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
